mem_arbiter: RTL and testbench

Shares the single instruction/data memory port between the instruction fetcher (IF port) and the load/store unit (LSU port) using the req/rdy/valid memory protocol. It allows one outstanding transaction at a time. The LSU has fixed priority, with a starvation guard for fetch. The block sits between the two requesters and the memory model/bus.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/LSU requesters, the arbiter and the shared memory port.
// The arbiter uses the slave modport; the requesters and memory side use master.
interface mem_arbiter_if #(
  parameter int unsigned bits = 32
);
  logic            if_req;
  logic [bits-1:0] IF_ADDR;
  logic            if_rdy;
  logic            if_valid;
  logic [bits-1:0] IF_RDATA;

  logic            lsu_req;
  logic            lsu_we;
  logic [bits-1:0] LSU_ADDR;
  logic [bits-1:0] LSU_WDATA;
  logic            lsu_rdy;
  logic            lsu_valid;
  logic [bits-1:0] LSU_RDATA;

  logic            proc_req;
  logic            we;
  logic [bits-1:0] ADDR_OUT;
  logic [bits-1:0] WDATA;
  logic            mem_rdy;
  logic            valid;
  logic [bits-1:0] RDATA;

  logic            busy;

  modport slave (
    input  if_req, IF_ADDR, lsu_req, lsu_we, LSU_ADDR, LSU_WDATA, mem_rdy, valid, RDATA,
    output if_rdy, if_valid, IF_RDATA, lsu_rdy, lsu_valid, LSU_RDATA,
           proc_req, we, ADDR_OUT, WDATA, busy
  );

  modport master (
    output if_req, IF_ADDR, lsu_req, lsu_we, LSU_ADDR, LSU_WDATA, mem_rdy, valid, RDATA,
    input  if_rdy, if_valid, IF_RDATA, lsu_rdy, lsu_valid, LSU_RDATA,
           proc_req, we, ADDR_OUT, WDATA, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time.
// LSU has fixed priority; fetch wins after MAX_STARVE consecutive LSU grants taken while it waited.
module mem_arbiter #(
  parameter int unsigned bits       = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [bits-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [bits-1:0] wdata_q, wdata_d;
  logic [bits-1:0] if_rdata_q, if_rdata_d;
  logic [bits-1:0] lsu_rdata_q, lsu_rdata_d;
  logic            if_rdy_q, if_rdy_d;
  logic            lsu_rdy_q, lsu_rdy_d;
  logic            if_valid_q, if_valid_d;
  logic            lsu_valid_q, lsu_valid_d;
  logic            proc_req_q, proc_req_d;
  logic            busy_q, busy_d;

  logic            starve_at_max_c;
  logic            lsu_wins_c;

  // Fetch only overrides the LSU once it has been passed over MAX_STARVE times in a row.
  assign starve_at_max_c = (starve_q == CNT_W'(MAX_STARVE));
  assign lsu_wins_c      = bus.lsu_req && !(bus.if_req && starve_at_max_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    if_rdy_d    = 1'b0;
    lsu_rdy_d   = 1'b0;
    if_valid_d  = 1'b0;
    lsu_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.lsu_req) begin
          state_d = ADDR;
          if (lsu_wins_c) begin
            owner_d   = 1'b1;
            addr_d    = bus.LSU_ADDR;
            we_d      = bus.lsu_we;
            wdata_d   = bus.LSU_WDATA;
            lsu_rdy_d = 1'b1;
            starve_d  = bus.if_req ? starve_q + CNT_W'(1) : '0;
          end else begin
            owner_d  = 1'b0;
            addr_d   = bus.IF_ADDR;
            we_d     = 1'b0;
            wdata_d  = '0;
            if_rdy_d = 1'b1;
            starve_d = '0;
          end
        end
      end
      ADDR: begin
        if (bus.mem_rdy) state_d = RESP;
      end
      RESP: begin
        if (bus.valid) begin
          state_d = IDLE;
          if (owner_q) begin
            lsu_rdata_d = bus.RDATA;
            lsu_valid_d = 1'b1;
          end else begin
            if_rdata_d = bus.RDATA;
            if_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    proc_req_d = (state_d == ADDR);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
      if_rdy_q    <= 1'b0;
      lsu_rdy_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      lsu_valid_q <= 1'b0;
      proc_req_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      if_rdy_q    <= if_rdy_d;
      lsu_rdy_q   <= lsu_rdy_d;
      if_valid_q  <= if_valid_d;
      lsu_valid_q <= lsu_valid_d;
      proc_req_q  <= proc_req_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_rdy    = if_rdy_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.IF_RDATA  = if_rdata_q;
  assign bus.lsu_rdy   = lsu_rdy_q;
  assign bus.lsu_valid = lsu_valid_q;
  assign bus.LSU_RDATA = lsu_rdata_q;
  assign bus.proc_req  = proc_req_q;
  assign bus.we        = we_q;
  assign bus.ADDR_OUT  = addr_q;
  assign bus.WDATA     = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned BITS       = 32;
  localparam int          MAX_STARVE = 4;

  logic clk;
  logic rst;

  mem_arbiter_if #(.bits(BITS)) bus ();

  mem_arbiter #(.bits(BITS), .MAX_STARVE(MAX_STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_pass;

  // Reference model: one pending transaction, described by who owns it and how far it got.
  bit        m_pending;
  bit        m_mem_took_addr;
  bit        m_lsu_owns;
  int        m_starve;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_lsu_rdata;
  logic        e_we, e_if_rdy, e_lsu_rdy, e_if_valid, e_lsu_valid, e_proc_req, e_busy;

  logic [31:0] dut_log;
  int          proc_cnt;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Advance the model by one clock edge using the inputs that are about to be sampled.
  function automatic void model_edge();
    e_if_rdy    = 1'b0;
    e_lsu_rdy   = 1'b0;
    e_if_valid  = 1'b0;
    e_lsu_valid = 1'b0;
    if (!rst) begin
      m_pending = 0; m_mem_took_addr = 0; m_lsu_owns = 0; m_starve = 0;
      e_addr = '0; e_wdata = '0; e_we = 1'b0; e_if_rdata = '0; e_lsu_rdata = '0;
    end else if (!m_pending) begin
      if (bus.if_req || bus.lsu_req) begin
        m_lsu_owns = bus.lsu_req && !(bus.if_req && m_starve == MAX_STARVE);
        if (m_lsu_owns) begin
          e_addr = bus.LSU_ADDR; e_we = bus.lsu_we; e_wdata = bus.LSU_WDATA;
          e_lsu_rdy = 1'b1;
          m_starve = bus.if_req ? m_starve + 1 : 0;
        end else begin
          e_addr = bus.IF_ADDR; e_we = 1'b0; e_wdata = '0;
          e_if_rdy = 1'b1;
          m_starve = 0;
        end
        m_pending = 1;
        m_mem_took_addr = 0;
      end
    end else if (!m_mem_took_addr) begin
      m_mem_took_addr = bus.mem_rdy;
    end else if (bus.valid) begin
      if (m_lsu_owns) begin e_lsu_rdata = bus.RDATA; e_lsu_valid = 1'b1; end
      else begin e_if_rdata = bus.RDATA; e_if_valid = 1'b1; end
      m_pending = 0;
    end
    e_proc_req = m_pending && !m_mem_took_addr;
    e_busy     = m_pending;
  endfunction

  // One clock: update model, let the edge pass, compare every output on the falling edge.
  task automatic step();
    model_edge();
    @(negedge clk);
    check("if_rdy",    32'(bus.if_rdy),    32'(e_if_rdy));
    check("lsu_rdy",   32'(bus.lsu_rdy),   32'(e_lsu_rdy));
    check("if_valid",  32'(bus.if_valid),  32'(e_if_valid));
    check("lsu_valid", 32'(bus.lsu_valid), 32'(e_lsu_valid));
    check("IF_RDATA",  bus.IF_RDATA,       e_if_rdata);
    check("LSU_RDATA", bus.LSU_RDATA,      e_lsu_rdata);
    check("proc_req",  32'(bus.proc_req),  32'(e_proc_req));
    check("we",        32'(bus.we),        32'(e_we));
    check("ADDR_OUT",  bus.ADDR_OUT,       e_addr);
    check("WDATA",     bus.WDATA,          e_wdata);
    check("busy",      32'(bus.busy),      32'(e_busy));
    if (bus.lsu_rdy === 1'b1) dut_log = {dut_log[30:0], 1'b1};
    if (bus.if_rdy === 1'b1)  dut_log = {dut_log[30:0], 1'b0};
    if (bus.proc_req === 1'b1) proc_cnt++;
  endtask

  // Memory side of one transaction, starting in the address phase.
  task automatic serve(int a_wait, int r_wait, logic [31:0] rd);
    bus.mem_rdy = 1'b0;
    repeat (a_wait) step();
    bus.mem_rdy = 1'b1;
    step();
    bus.mem_rdy = 1'b0;
    repeat (r_wait) step();
    bus.valid = 1'b1;
    bus.RDATA = rd;
    step();
    bus.valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; dut_log = '0; proc_cnt = 0;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.IF_ADDR = '0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.LSU_ADDR = '0; bus.LSU_WDATA = '0;
    bus.mem_rdy = 1'b0; bus.valid = 1'b0; bus.RDATA = '0;

    // Reset values
    step(); step();
    rst = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", bus.ADDR_OUT, 32'd0);
    check("rst_if_rdata", bus.IF_RDATA, 32'd0);

    // Single IF read
    bus.if_req = 1'b1; bus.IF_ADDR = 32'h0000_0010;
    step();
    check("if1_rdy", 32'(bus.if_rdy), 32'd1);
    check("if1_addr", bus.ADDR_OUT, 32'h10);
    check("if1_proc_req", 32'(bus.proc_req), 32'd1);
    bus.if_req = 1'b0;
    serve(0, 1, 32'h0050_0093);
    check("if1_valid", 32'(bus.if_valid), 32'd1);
    check("if1_rdata", bus.IF_RDATA, 32'h0050_0093);
    check("if1_lsu_rdata", bus.LSU_RDATA, 32'd0);
    step();
    check("if1_valid_pulse", 32'(bus.if_valid), 32'd0);

    // Simultaneous requests: LSU first, then IF at the next idle edge
    dut_log = '0;
    bus.if_req = 1'b1; bus.IF_ADDR = 32'h20;
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.LSU_ADDR = 32'h100;
    step();
    check("sim_lsu_addr", bus.ADDR_OUT, 32'h100);
    bus.lsu_req = 1'b0;
    serve(0, 0, 32'hCAFE_0001);
    check("sim_lsu_valid", 32'(bus.lsu_valid), 32'd1);
    step();
    check("sim_if_rdy", 32'(bus.if_rdy), 32'd1);
    check("sim_if_addr", bus.ADDR_OUT, 32'h20);
    bus.if_req = 1'b0;
    serve(1, 0, 32'hCAFE_0002);
    check("sim_order", dut_log, 32'h2);

    // Starvation guard: IF held, LSU always re-requesting
    dut_log = '0;
    bus.if_req = 1'b1; bus.IF_ADDR = 32'h40;
    bus.lsu_req = 1'b1; bus.LSU_ADDR = 32'h140;
    for (int g = 0; g < 6; g++) begin
      step();
      if (bus.if_rdy === 1'b1) bus.if_req = 1'b0;
      serve(0, 0, $urandom);
    end
    bus.lsu_req = 1'b0;
    check("starve_order", dut_log, 32'h3D);

    // LSU write with a slow address phase
    proc_cnt = 0;
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.LSU_ADDR = 32'h200; bus.LSU_WDATA = 32'hDEAD_BEEF;
    step();
    check("wr_we", 32'(bus.we), 32'd1);
    check("wr_wdata", bus.WDATA, 32'hDEAD_BEEF);
    check("wr_addr", bus.ADDR_OUT, 32'h200);
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0;
    serve(3, 0, $urandom);
    check("wr_proc_cycles", 32'(proc_cnt), 32'd4);
    check("wr_lsu_valid", 32'(bus.lsu_valid), 32'd1);
    step();

    // Stray mem_rdy / valid outside their phases
    bus.valid = 1'b1;
    step();
    check("stray_idle_busy", 32'(bus.busy), 32'd0);
    bus.valid = 1'b0;
    bus.if_req = 1'b1; bus.IF_ADDR = 32'h80;
    step();
    bus.if_req = 1'b0;
    bus.valid = 1'b1;
    step();
    check("stray_addr_proc_req", 32'(bus.proc_req), 32'd1);
    bus.mem_rdy = 1'b1;
    step();
    check("stray_both_if_valid", 32'(bus.if_valid), 32'd0);
    bus.valid = 1'b0;
    step();
    check("stray_resp_busy", 32'(bus.busy), 32'd1);
    bus.mem_rdy = 1'b0; bus.valid = 1'b1; bus.RDATA = 32'h0000_1234;
    step();
    check("stray_if_rdata", bus.IF_RDATA, 32'h1234);
    bus.valid = 1'b0;
    step();

    // Reset while waiting for the response
    bus.lsu_req = 1'b1; bus.LSU_ADDR = 32'h300;
    step();
    bus.lsu_req = 1'b0;
    bus.mem_rdy = 1'b1;
    step();
    bus.mem_rdy = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1; bus.valid = 1'b1; bus.RDATA = 32'h5555_AAAA;
    step();
    check("rstm_lsu_valid", 32'(bus.lsu_valid), 32'd0);
    check("rstm_busy", 32'(bus.busy), 32'd0);
    check("rstm_addr", bus.ADDR_OUT, 32'd0);
    check("rstm_lsu_rdata", bus.LSU_RDATA, 32'd0);
    check("rstm_if_rdata", bus.IF_RDATA, 32'd0);
    bus.valid = 1'b0;

    // Random traffic including stray handshakes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (bus.if_rdy === 1'b1) bus.if_req = 1'b0;
      if (bus.lsu_rdy === 1'b1) bus.lsu_req = 1'b0;
      if (!bus.if_req && $urandom_range(2) == 0) begin
        bus.if_req = 1'b1; bus.IF_ADDR = $urandom;
      end
      if (!bus.lsu_req && $urandom_range(3) != 0) begin
        bus.lsu_req = 1'b1; bus.lsu_we = 1'($urandom_range(1));
        bus.LSU_ADDR = $urandom; bus.LSU_WDATA = $urandom;
      end
      bus.mem_rdy = 1'($urandom_range(1));
      bus.valid   = 1'($urandom_range(1));
      bus.RDATA   = $urandom;
      rst         = ($urandom_range(63) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
